// File: rtl/fifo_mac_pkg.sv
// fifo_mac_pkg: shared defaults and controller state type for the FIFO-fed
// dot-product engine.
//   DEF_DATA_W : operand width of each FIFO word
//   DEF_LEN    : operand pairs per dot product (1..256)
//   DEF_ACC_W  : accumulator / result width
//   state_t    : controller states IDLE, RUN, DRAIN, DONE
package fifo_mac_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN    = 8;
  localparam int DEF_ACC_W  = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fifo_mac_if.sv
// fifo_mac_if: handshake/bus bundle between fifo_mac and its environment.
//   start            : request one dot product
//   a_empty, b_empty : upstream FIFO empty flags
//   a_data, b_data   : FIFO read data, valid the cycle after rden
//   a_rden, b_rden   : FIFO read enables
//   busy, done       : computation in progress / one-cycle completion pulse
//   result           : dot product, held until the next completion
// Modports: slave = fifo_mac, master = the FIFO/requester side.
interface fifo_mac_if
  import fifo_mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
);

  logic              start;
  logic              a_empty;
  logic              b_empty;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic              a_rden;
  logic              b_rden;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  result;

  modport master (
    output start, a_empty, b_empty, a_data, b_data,
    input  a_rden, b_rden, busy, done, result
  );

  modport slave (
    input  start, a_empty, b_empty, a_data, b_data,
    output a_rden, b_rden, busy, done, result
  );

endinterface

// File: rtl/fifo_mac_mac.sv
// mac: multiply-accumulate datapath.
//   clk, rst : clock, asynchronous active-high reset
//   en       : accumulate a*b this cycle
//   clr      : clear the accumulator (wins over en)
//   a, b     : unsigned operands
//   acc      : running sum, wraps modulo 2^ACC_W
module mac
  import fifo_mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] w_prod;

  assign w_prod = a * b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(w_prod);
    end
  end

endmodule

// File: rtl/fifo_mac.sv
// fifo_mac: reads LEN operand pairs from two upstream FIFOs and returns
// their unsigned dot product.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fifo_mac_if slave (start, FIFO flags/data/rden, busy, done,
//              result)
module fifo_mac
  import fifo_mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN    = DEF_LEN,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic      clk,
  input  logic      rst,
  fifo_mac_if.slave bus
);

  localparam int               CNT_W  = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LEN - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_issued;
  logic [CNT_W-1:0]   r_accepted;
  logic               r_valid;
  logic [ACC_W-1:0]   r_result;
  logic [ACC_W-1:0]   w_acc;
  logic               w_rd;
  logic               w_clr;

  assign w_rd  = (r_state == RUN) && !bus.a_empty && !bus.b_empty &&
                 (r_issued < LEN_C);
  assign w_clr = (r_state == IDLE) && bus.start;

  mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .en  (r_valid),
    .clr (w_clr),
    .a   (bus.a_data),
    .b   (bus.b_data),
    .acc (w_acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_issued   <= '0;
      r_accepted <= '0;
      r_valid    <= 1'b0;
      r_result   <= '0;
    end else begin
      // Data returns one cycle after its read enable.
      r_valid <= w_rd;
      if (r_valid) begin
        r_accepted <= r_accepted + CNT_W'(1);
      end
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_issued   <= '0;
            r_accepted <= '0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          if (w_rd) begin
            r_issued <= r_issued + CNT_W'(1);
            if (r_issued == LAST_C) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (r_valid && (r_accepted == LAST_C)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_result <= w_acc;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The accumulator is final and frozen throughout DONE, so it is shown
  // directly in that cycle and captured into r_result as DONE exits; the
  // visible result therefore changes exactly on entry to DONE.
  assign bus.a_rden = w_rd;
  assign bus.b_rden = w_rd;
  assign bus.busy   = (r_state != IDLE);
  assign bus.done   = (r_state == DONE);
  assign bus.result = (r_state == DONE) ? w_acc : r_result;

endmodule

// File: tb/tb_fifo_mac.sv
// tb_fifo_mac: bench for fifo_mac with queue-based FIFO models, a
// transaction-level reference (reads, running sum, done two cycles after the
// last read) and a per-cycle output comparison.
module tb_fifo_mac;
  import fifo_mac_pkg::*;

  localparam int DW = 8;
  localparam int L  = 8;
  localparam int AW = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_mac_if #(.DATA_W(DW), .ACC_W(AW)) bus ();

  fifo_mac #(.DATA_W(DW), .LEN(L), .ACC_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  bit stall_a, stall_b, rand_stall;
  bit rd_s, start_s;

  // reference model
  bit            m_busy, m_done;
  int            m_reads, done_at;
  logic [AW-1:0] m_sum, m_res;

  // observations for the literal checks
  int start_cyc, first_rd_cyc, last_rd_cyc, last_done_cyc, done_cnt, rd_cnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic upd_flags();
    bus.a_empty = (qa.size() == 0) || stall_a;
    bus.b_empty = (qb.size() == 0) || stall_b;
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
    qa.push_back(a);
    qb.push_back(b);
    upd_flags();
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_reads = 0; done_at = -1;
    m_sum = '0; m_res = '0;
  endtask

  // Per-cycle comparison of every output against the model.
  task automatic compare_cycle();
    bit exp_rd;
    exp_rd = m_busy && (m_reads < L) && !bus.a_empty && !bus.b_empty;
    check("a_rden", 32'(bus.a_rden), 32'(exp_rd));
    check("b_rden", 32'(bus.b_rden), 32'(exp_rd));
    check("busy",   32'(bus.busy),   32'(m_busy));
    check("done",   32'(bus.done),   32'(m_done));
    check("result", 32'(bus.result), 32'(m_res));
    if (bus.done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    rd_s    = bus.a_rden && bus.b_rden;
    start_s = bus.start;
  endtask

  task automatic tick();
    bit was_busy;
    logic [DW-1:0] a, b;
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    was_busy = m_busy;
    if (m_done) begin
      m_busy = 0;
      m_done = 0;
    end
    if (!was_busy && start_s && !rst) begin
      m_busy = 1; m_reads = 0; m_sum = '0; done_at = -1;
    end
    if (rd_s) begin
      a = qa.pop_front();
      b = qb.pop_front();
      bus.a_data = a;
      bus.b_data = b;
      m_sum = m_sum + AW'(int'(a) * int'(b));
      m_reads++;
      rd_cnt++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      last_rd_cyc = cyc;
      if (m_reads == L) done_at = cyc + 2;
    end
    cyc++;
    m_done = m_busy && (cyc == done_at);
    if (m_done) m_res = m_sum;
    if (rand_stall) begin
      stall_a = ($urandom_range(0, 3) == 0);
      stall_b = ($urandom_range(0, 3) == 0);
    end
    upd_flags();
  endtask

  task automatic start_pulse();
    bus.start    = 1'b1;
    start_cyc    = cyc;
    done_cnt     = 0;
    rd_cnt       = 0;
    first_rd_cyc = -1;
    last_rd_cyc  = -1;
    last_done_cyc = -1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (m_busy && n < maxc) begin
      tick();
      n++;
    end
    if (m_busy) check("timeout", 32'd1, 32'd0);
    tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_a_rden"}, 32'(bus.a_rden), 32'd0);
    check({tag, "_b_rden"}, 32'(bus.b_rden), 32'd0);
    check({tag, "_busy"},   32'(bus.busy),   32'd0);
    check({tag, "_done"},   32'(bus.done),   32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'd0);
  endtask

  logic [AW-1:0] res1, exp_r;
  int n;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a_data = '0;
    bus.b_data = '0;
    stall_a = 0; stall_b = 0; rand_stall = 0;
    rd_s = 0; start_s = 0;
    model_reset();
    upd_flags();
    #2;
    check_outputs_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // A=1..8, B=2: reads cycles 1..8, done cycle 10, result 72
    for (int i = 1; i <= 8; i++) push(DW'(i), 8'd2);
    start_pulse();
    wait_idle(60);
    check("s1_first_rd", 32'(first_rd_cyc - start_cyc), 32'd1);
    check("s1_last_rd",  32'(last_rd_cyc - start_cyc),  32'd8);
    check("s1_done_cyc", 32'(last_done_cyc - start_cyc), 32'd10);
    check("s1_result",   32'(bus.result), 32'd72);
    check("s1_model",    32'(m_res),      32'd72);
    res1 = bus.result;

    // all 0xFF operands
    for (int i = 0; i < 8; i++) push(8'hFF, 8'hFF);
    start_pulse();
    wait_idle(60);
    check("s2_result", 32'(bus.result), 32'h07F008);
    check("s2_model",  32'(m_res),      32'd520200);

    // B runs dry after 3 words for 5 cycles
    for (int i = 1; i <= 8; i++) qa.push_back(DW'(i));
    for (int i = 0; i < 3; i++) qb.push_back(8'd2);
    upd_flags();
    start_pulse();
    n = 0;
    while (m_reads < 3 && n < 50) begin tick(); n++; end
    repeat (5) tick();
    for (int i = 0; i < 5; i++) qb.push_back(8'd2);
    upd_flags();
    wait_idle(60);
    check("s3_result",   32'(bus.result), 32'(res1));
    check("s3_done_cyc", 32'(last_done_cyc - start_cyc), 32'd15);
    check("s3_reads",    32'(rd_cnt), 32'd8);

    // start re-asserted mid-RUN
    for (int i = 1; i <= 8; i++) push(DW'(i), 8'd3);
    start_pulse();
    repeat (3) tick();
    bus.start = 1'b1;
    tick();
    tick();
    bus.start = 1'b0;
    wait_idle(60);
    repeat (3) tick();
    check("s4_reads",  32'(rd_cnt),   32'd8);
    check("s4_dones",  32'(done_cnt), 32'd1);
    check("s4_result", 32'(bus.result), 32'd108);

    // reset after 4 reads, then fresh computation
    for (int i = 1; i <= 8; i++) push(DW'(i), 8'd5);
    start_pulse();
    n = 0;
    while (rd_cnt < 4 && n < 50) begin tick(); n++; end
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    model_reset();
    tick();
    rst = 1'b0;
    qa.delete();
    qb.delete();
    for (int i = 8; i >= 1; i--) push(DW'(i), 8'd3);
    tick();
    start_pulse();
    wait_idle(60);
    check("s5_result", 32'(bus.result), 32'd108);

    // back-to-back computations
    for (int i = 1; i <= 8; i++) push(DW'(i), 8'd1);
    for (int i = 1; i <= 8; i++) push(DW'(i), 8'd2);
    start_pulse();
    wait_idle(60);
    check("s6_first", 32'(bus.result), 32'd36);
    start_pulse();
    wait_idle(60);
    check("s6_second", 32'(bus.result), 32'd72);

    // randomized data and FIFO stalls
    for (int j = 0; j < 8; j++) begin
      exp_r = '0;
      for (int i = 0; i < 8; i++) begin
        logic [DW-1:0] a, b;
        a = DW'($urandom);
        b = DW'($urandom);
        qa.push_back(a);
        qb.push_back(b);
        exp_r = exp_r + AW'(int'(a) * int'(b));
      end
      upd_flags();
      repeat ($urandom_range(0, 3)) tick();
      rand_stall = 1;
      start_pulse();
      wait_idle(300);
      rand_stall = 0;
      stall_a = 0;
      stall_b = 0;
      upd_flags();
      check("rand_result", 32'(bus.result), 32'(exp_r));
      check("rand_dones",  32'(done_cnt), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_mac.md
FIFO_MAC -- requirements
Module: fifo_mac

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning operand width of each FIFO word.
REQ-002 The block SHALL have parameter LEN, default 8, meaning number of operand pairs per dot product (1..256).
REQ-003 The block SHALL have parameter ACC_W, default 24, meaning accumulator/result width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, all state updates on posedge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: request one dot product (sampled on posedge).
REQ-007 The block SHALL have ports a_empty and b_empty, input, 1 bit each: empty flags of the A and B upstream FIFOs.
REQ-008 The block SHALL have ports a_data and b_data, input, DATA_W bits each: FIFO read data, valid the cycle after the corresponding rden.
REQ-009 The block SHALL have ports a_rden and b_rden, output, 1 bit each: FIFO read enables.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a computation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-012 The block SHALL have port result, output, ACC_W bits: the dot product, held stable.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE: start=1 SHALL clear the accumulator and the issue/accept counters and move to RUN; start=0 SHALL remain in IDLE.
REQ-015 RUN: a_rden and b_rden SHALL be asserted together, combinationally, only when !a_empty && !b_empty && issued<LEN.
REQ-016 Neither rden SHALL ever be asserted when its FIFO is empty, nor one without the other.
REQ-017 Each read SHALL increment issued; RUN SHALL go to DRAIN on the edge where the LEN-th read issues.
REQ-018 A 1-cycle valid flag (registered rden) SHALL qualify data; when valid, acc <= acc + a_data*b_data (unsigned, product 2*DATA_W bits, zero-extended, sum wraps mod 2^ACC_W), and accepted increments.
REQ-019 DRAIN SHALL move to DONE when accepted reaches LEN.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE; result SHALL be loaded from acc on entry to DONE.
REQ-021 busy SHALL be 1 in RUN, DRAIN, and DONE; 0 in IDLE.
REQ-022 With both FIFOs non-empty throughout and start in cycle 0, reads SHALL occur in cycles 1..LEN and done SHALL be high in cycle LEN+2.
REQ-023 An empty FIFO mid-RUN SHALL stall reads without losing accumulated state; reads SHALL resume when both flags are non-empty.
REQ-024 start while busy SHALL be ignored.
REQ-025 result SHALL hold its value until the next DONE.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, with acc, result, counters, and the valid flag at 0, and busy=done=a_rden=b_rden=0.
REQ-027 Reset mid-operation SHALL abandon the computation; already-read FIFO data is not recovered.

Structure
REQ-028 A shared package fifo_mac_pkg SHALL hold DATA_W, LEN, and ACC_W defaults and the state enum type.
REQ-029 The datapath SHALL be a sub-module mac (inputs en, clr, a, b; output acc); the controller and counters SHALL reside in fifo_mac.

Verification
REQ-030 The bench SHALL cover: FIFOs preloaded with A=1..8, B=all 2, start pulse -> reads in cycles 1..8, done in cycle 10, result=72.
REQ-031 The bench SHALL cover: A=B=0xFF ×8 -> result=0x07F008 (520200).
REQ-032 The bench SHALL cover: B empty after 3 words for 5 cycles, then refilled -> no rden while empty, result unchanged from the unstalled run, done delayed by 5 cycles.
REQ-033 The bench SHALL cover: start re-asserted in the middle of RUN -> ignored, exactly 8 reads, one done pulse.
REQ-034 The bench SHALL cover: rst asserted after 4 reads -> outputs 0 same cycle, IDLE; a new start with 8 fresh pairs -> correct result from a cleared accumulator.
REQ-035 The bench SHALL cover: two back-to-back computations (1..8·1 then 1..8·2) -> results 36 then 72, result stable between done pulses.
